// File: rtl/tcbm_drive_link.sv
// Drive-side TCBM DAV/ACK handshake engine: a code byte then one data byte per transfer,
// bridged to the SD backend through valid/ready byte streams.
module tcbm_drive_link #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  CODE_CMD       = 8'h81,
    parameter logic [7:0]  CODE_WR        = 8'h83,
    parameter logic [7:0]  CODE_RD        = 8'h84
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dav_n,
    output logic       ack_n,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic [1:0] status,
    output logic [7:0] rx_data,
    output logic       rx_cmd,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle, StCodeRel, StBadRel, StWrWait, StWrPush, StRdWait, StRdFetch, StDataRel
    } state_t;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_dav_sync;
    logic [7:0]             r_code;
    logic [15:0]            r_cnt;
    logic                   r_rd_loaded;
    logic                   r_ack_n;
    logic [7:0]             r_bus_out;
    logic                   r_bus_oe;
    logic [1:0]             r_status;
    logic [7:0]             r_rx_data;
    logic                   r_rx_cmd;
    logic                   r_rx_valid;
    logic                   r_tx_ready;

    logic w_dav_s;
    logic w_timeout;
    logic w_code_ok;

    assign w_dav_s   = r_dav_sync[SYNC_STAGES-1];
    assign w_timeout = (r_cnt == TimeoutLast);
    assign w_code_ok = (bus_in == CODE_CMD) || (bus_in == CODE_WR) || (bus_in == CODE_RD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dav_sync <= '1;
        end else begin
            r_dav_sync <= {r_dav_sync[SYNC_STAGES-2:0], dav_n};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_code      <= 8'h00;
            r_cnt       <= 16'd0;
            r_rd_loaded <= 1'b0;
            r_ack_n     <= 1'b1;
            r_bus_out   <= 8'h00;
            r_bus_oe    <= 1'b0;
            r_status    <= 2'b00;
            r_rx_data   <= 8'h00;
            r_rx_cmd    <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
        end else begin
            r_tx_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_dav_s) begin
                        r_code  <= bus_in;
                        r_ack_n <= 1'b0;
                        if (w_code_ok) begin
                            r_state <= StCodeRel;
                        end else begin
                            r_status <= 2'b11;
                            r_state  <= StBadRel;
                        end
                    end
                end
                StCodeRel: begin
                    if (w_dav_s) begin
                        r_ack_n <= 1'b1;
                        r_state <= (r_code == CODE_RD) ? StRdWait : StWrWait;
                    end
                end
                StBadRel: begin
                    if (w_dav_s) begin
                        r_ack_n  <= 1'b1;
                        r_status <= 2'b00;
                        r_state  <= StIdle;
                    end
                end
                StWrWait: begin
                    if (!w_dav_s) begin
                        r_rx_data  <= bus_in;
                        r_rx_cmd   <= (r_code == CODE_CMD);
                        r_rx_valid <= 1'b1;
                        r_cnt      <= 16'd0;
                        r_state    <= StWrPush;
                    end
                end
                StWrPush: begin
                    // Accept is tested first so it wins over a coincident final count.
                    if (rx_ready) begin
                        r_rx_valid <= 1'b0;
                        r_status   <= 2'b00;
                        r_ack_n    <= 1'b0;
                        r_state    <= StDataRel;
                    end else if (w_timeout) begin
                        r_rx_valid <= 1'b0;
                        r_status   <= 2'b01;
                        r_ack_n    <= 1'b0;
                        r_state    <= StDataRel;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StRdWait: begin
                    if (!w_dav_s) begin
                        r_cnt       <= 16'd0;
                        r_rd_loaded <= 1'b0;
                        r_state     <= StRdFetch;
                    end
                end
                StRdFetch: begin
                    // Byte goes on the bus one clock before ACK to give the host setup time.
                    if (r_rd_loaded) begin
                        r_ack_n     <= 1'b0;
                        r_rd_loaded <= 1'b0;
                        r_state     <= StDataRel;
                    end else if (tx_valid) begin
                        r_tx_ready  <= 1'b1;
                        r_bus_out   <= tx_data;
                        r_bus_oe    <= 1'b1;
                        r_status    <= tx_eoi ? 2'b10 : 2'b00;
                        r_rd_loaded <= 1'b1;
                    end else if (w_timeout) begin
                        r_bus_out <= 8'h00;
                        r_bus_oe  <= 1'b1;
                        r_status  <= 2'b01;
                        r_ack_n   <= 1'b0;
                        r_state   <= StDataRel;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StDataRel: begin
                    if (w_dav_s) begin
                        r_ack_n  <= 1'b1;
                        r_bus_oe <= 1'b0;
                        r_status <= 2'b00;
                        r_state  <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ack_n    = r_ack_n;
    assign bus_out  = r_bus_out;
    assign bus_oe   = r_bus_oe;
    assign status   = r_status;
    assign rx_data  = r_rx_data;
    assign rx_cmd   = r_rx_cmd;
    assign rx_valid = r_rx_valid;
    assign tx_ready = r_tx_ready;
    assign busy     = (r_state != StIdle);

endmodule
